// File: rtl/cpu_bus_initiator_if.sv
// Local-bus signal bundle between the 8088 bus initiator (master) and the chipset (slave).
interface cpu_bus_initiator_if;
  logic [19:0] ADDRESS;
  logic [7:0]  DATA_OUT;
  logic [7:0]  DATA_IN;
  logic        bus_oe;
  logic        RD_N;
  logic        WR_N;
  logic        INTA_N;
  logic        IO_OR_M;
  logic        DT_OR_R;
  logic        DEN_N;
  logic        ALE;
  logic        RDY;
  logic        HOLD;
  logic        HLDA;

  modport master (
    output ADDRESS, DATA_OUT, bus_oe, RD_N, WR_N, INTA_N, IO_OR_M, DT_OR_R, DEN_N, ALE, HLDA,
    input  DATA_IN, RDY, HOLD
  );

  modport slave (
    input  ADDRESS, DATA_OUT, bus_oe, RD_N, WR_N, INTA_N, IO_OR_M, DT_OR_R, DEN_N, ALE, HLDA,
    output DATA_IN, RDY, HOLD
  );
endinterface

// File: rtl/cpu_bus_initiator.sv
// 8088 minimum-mode bus initiator: turns single core requests into T1..T4 cycles with
// wait states, HOLD/HLDA arbitration and the two-part interrupt acknowledge.
module cpu_bus_initiator #(
  parameter int MAX_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_clock_posedge,
  input  logic        cpu_clock_negedge,
  input  logic        req,
  input  logic [2:0]  req_type,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        timeout,
  cpu_bus_initiator_if.master bus
);

  typedef enum logic [2:0] {
    S_TI, S_T1, S_T2, S_T3, S_TW, S_T4, S_TH, S_GAP
  } state_e;

  localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

  function automatic logic type_is_write(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd3);
  endfunction

  function automatic logic type_is_inta(input logic [2:0] t);
    return (t == 3'd4);
  endfunction

  function automatic logic type_is_io(input logic [2:0] t);
    return (t == 3'd2) || (t == 3'd3) || (t == 3'd4);
  endfunction

  state_e      state_q;
  logic [2:0]  type_q;
  logic [15:0] wait_q;
  logic        gap_q;
  logic        inta2_q;
  logic [19:0] addr_q;
  logic [7:0]  dout_q;
  logic [7:0]  rdata_q;
  logic        ack_q, timeout_q, ale_q, rd_n_q, wr_n_q, inta_n_q, den_n_q;
  logic        io_m_q, dt_r_q, hlda_q, oe_q;
  logic        first_half_s, go_t1_s, go_th_s;

  assign first_half_s = type_is_inta(type_q) && !inta2_q;

  // Exit decision shared by TI and the end of T4; HOLD outranks a pending request,
  // and the first INTA half always continues into the gap.
  always_comb begin
    go_t1_s = 1'b0;
    go_th_s = 1'b0;
    case (state_q)
      S_TI: begin
        if (bus.HOLD) go_th_s = 1'b1;
        else if (req) go_t1_s = 1'b1;
        else go_t1_s = 1'b0;
      end
      S_T4: begin
        if (first_half_s) go_t1_s = 1'b0;
        else if (bus.HOLD) go_th_s = 1'b1;
        else if (req) go_t1_s = 1'b1;
        else go_t1_s = 1'b0;
      end
      default: go_t1_s = 1'b0;
    endcase
  end

  // Bus-cycle sequencer with registered bus and core outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_TI;
      type_q    <= 3'd0;
      wait_q    <= 16'd0;
      gap_q     <= 1'b0;
      inta2_q   <= 1'b0;
      addr_q    <= 20'd0;
      dout_q    <= 8'd0;
      rdata_q   <= 8'd0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      ale_q     <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      inta_n_q  <= 1'b1;
      den_n_q   <= 1'b1;
      io_m_q    <= 1'b0;
      dt_r_q    <= 1'b0;
      hlda_q    <= 1'b0;
      oe_q      <= 1'b1;
    end else begin
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      if (cpu_clock_negedge) ale_q <= 1'b0;
      if (cpu_clock_posedge) begin
        if (go_t1_s) begin
          state_q <= S_T1;
          type_q  <= req_type;
          inta2_q <= 1'b0;
          wait_q  <= 16'd0;
          ale_q   <= 1'b1;
          addr_q  <= type_is_inta(req_type) ? 20'd0 : req_address;
          dout_q  <= type_is_write(req_type) ? req_wdata : 8'd0;
          io_m_q  <= type_is_io(req_type);
          dt_r_q  <= type_is_write(req_type);
        end else if (go_th_s) begin
          state_q <= S_TH;
          inta2_q <= 1'b0;
          hlda_q  <= 1'b1;
          oe_q    <= 1'b0;
        end else begin
          case (state_q)
            S_TI: state_q <= S_TI;
            S_T1: begin
              state_q  <= S_T2;
              ale_q    <= 1'b0;
              rd_n_q   <= type_is_write(type_q) || type_is_inta(type_q);
              wr_n_q   <= !type_is_write(type_q);
              inta_n_q <= !type_is_inta(type_q);
              den_n_q  <= 1'b0;
            end
            S_T2: state_q <= S_T3;
            S_T3, S_TW: begin
              if (!bus.RDY && ((MAX_W == 16'd0) || (wait_q < MAX_W))) begin
                state_q <= S_TW;
                wait_q  <= wait_q + 16'd1;
              end else begin
                state_q  <= S_T4;
                rd_n_q   <= 1'b1;
                wr_n_q   <= 1'b1;
                inta_n_q <= 1'b1;
                den_n_q  <= 1'b1;
                // The first INTA half is a dummy cycle: no data, no ack, no timeout.
                if (!first_half_s) begin
                  ack_q     <= 1'b1;
                  timeout_q <= !bus.RDY;
                  if (!type_is_write(type_q)) rdata_q <= bus.RDY ? bus.DATA_IN : 8'hFF;
                end
              end
            end
            S_T4: begin
              if (first_half_s) begin
                state_q <= S_GAP;
                gap_q   <= 1'b0;
                inta2_q <= 1'b1;
              end else begin
                state_q <= S_TI;
              end
            end
            S_GAP: begin
              if (gap_q) begin
                state_q <= S_T1;
                wait_q  <= 16'd0;
                ale_q   <= 1'b1;
              end else begin
                gap_q <= 1'b1;
              end
            end
            S_TH: begin
              if (!bus.HOLD) begin
                state_q <= S_TI;
                hlda_q  <= 1'b0;
                oe_q    <= 1'b1;
              end else begin
                state_q <= S_TH;
              end
            end
            default: state_q <= S_TI;
          endcase
        end
      end
    end
  end

  assign ack          = ack_q;
  assign timeout      = timeout_q;
  assign rdata        = rdata_q;
  assign bus.ADDRESS  = addr_q;
  assign bus.DATA_OUT = dout_q;
  assign bus.bus_oe   = oe_q;
  assign bus.RD_N     = rd_n_q;
  assign bus.WR_N     = wr_n_q;
  assign bus.INTA_N   = inta_n_q;
  assign bus.IO_OR_M  = io_m_q;
  assign bus.DT_OR_R  = dt_r_q;
  assign bus.DEN_N    = den_n_q;
  assign bus.ALE      = ale_q;
  assign bus.HLDA     = hlda_q;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Bench for cpu_bus_initiator: directed vector table, randomized transfers against a
// transaction-level model, and hand-written INTA / HOLD / timeout / reset sequences.
module tb_cpu_bus_initiator;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [1:0] div = 2'd0;
  logic pe, ne;
  int unsigned edge_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic        req = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [19:0] req_address = 20'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        ack, timeout;
  logic [7:0]  rdata;
  logic        req2 = 1'b0;
  logic [2:0]  req2_type = 3'd0;
  logic [19:0] req2_address = 20'd0;
  logic [7:0]  req2_wdata = 8'd0;
  logic        ack2, timeout2;
  logic [7:0]  rdata2;

  cpu_bus_initiator_if bus0();
  cpu_bus_initiator_if bus2();

  cpu_bus_initiator #(.MAX_WAIT(0)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_clock_posedge(pe), .cpu_clock_negedge(ne),
    .req(req), .req_type(req_type), .req_address(req_address), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .timeout(timeout), .bus(bus0)
  );

  cpu_bus_initiator #(.MAX_WAIT(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .cpu_clock_posedge(pe), .cpu_clock_negedge(ne),
    .req(req2), .req_type(req2_type), .req_address(req2_address), .req_wdata(req2_wdata),
    .ack(ack2), .rdata(rdata2), .timeout(timeout2), .bus(bus2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) div <= div + 2'd1;
  assign pe = (div == 2'd0);
  assign ne = (div == 2'd2);
  always @(posedge clock) if (pe) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One non-INTA transfer on dut; RDY held low for nw decision edges starting at T3.
  task automatic xfer(input logic [2:0] t, input logic [19:0] a, input logic [7:0] wd,
                      input int nw, input logic [7:0] din, input logic [7:0] exp_rd,
                      input int exp_lat);
    bit seen_t1, done, shape_ok;
    int t1e, rel;
    logic exp_st, is_wr;
    seen_t1 = 1'b0; done = 1'b0; shape_ok = 1'b1; t1e = 0; rel = 0;
    is_wr = t[0];
    req_type = t; req_address = a; req_wdata = wd;
    bus0.DATA_IN = din; bus0.RDY = 1'b1; req = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clock);
      if (!seen_t1 && bus0.ALE) begin
        seen_t1 = 1'b1;
        t1e = int'(edge_cnt);
      end
      if (seen_t1) begin
        rel = int'(edge_cnt) - t1e;
        exp_st = (rel >= 1) && (rel <= 2 + nw);
        if (bus0.RD_N !== !(exp_st && !is_wr) || bus0.WR_N !== !(exp_st && is_wr) ||
            bus0.DEN_N !== !exp_st || bus0.INTA_N !== 1'b1 || (rel >= 1 && bus0.ALE))
          shape_ok = 1'b0;
        if (ack) begin
          done = 1'b1;
          chk("latency", rel + 1, exp_lat);
          chk("rdata", rdata, exp_rd);
          chk("timeout", timeout, 1'b0);
          chk("io_or_m", bus0.IO_OR_M, t[1]);
          chk("dt_or_r", bus0.DT_OR_R, is_wr);
          chk("address", bus0.ADDRESS, a);
          if (is_wr) chk("data_out", bus0.DATA_OUT, wd);
          chk("strobe_shape", shape_ok, 1'b1);
          req = 1'b0;
        end else if (pe) begin
          bus0.RDY = (rel + 1 >= 3 + nw);
        end
      end
    end
    if (!done) chk("ack_seen", 1'b0, 1'b1);
    @(negedge clock);
    chk("ack_width", ack, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [19:0] a;
    logic [7:0]  wd;
    int          nw;
    logic [7:0]  din;
    logic [7:0]  exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] model_rd;

  initial begin
    int pulses, acks, rise1, fall2, eh, ea, t1e;
    bit prev, early, bad_addr, granted, ok, done;
    logic [7:0] ack_rd;
    logic [2:0] rt;
    logic [19:0] ra;
    logic [7:0] rw, rd;
    int rn;

    vecs[0] = '{3'd0, 20'hF0000, 8'h00, 0, 8'h5A, 8'h5A, 4};
    vecs[1] = '{3'd3, 20'h000A0, 8'h3C, 3, 8'h00, 8'h5A, 7};
    vecs[2] = '{3'd2, 20'h00060, 8'h00, 1, 8'hC3, 8'hC3, 5};
    vecs[3] = '{3'd1, 20'h12345, 8'hA5, 0, 8'h00, 8'hC3, 4};
    vecs[4] = '{3'd0, 20'hFFFFF, 8'h00, 2, 8'h00, 8'h00, 6};

    bus0.DATA_IN = 8'h00; bus0.RDY = 1'b1; bus0.HOLD = 1'b0;
    bus2.DATA_IN = 8'h00; bus2.RDY = 1'b1; bus2.HOLD = 1'b0;

    #2 reset_n = 1'b0;
    #30;
    chk("rst_strobes", {bus0.RD_N, bus0.WR_N, bus0.INTA_N, bus0.DEN_N, bus0.ALE}, 5'b11110);
    chk("rst_ctrl", {bus0.bus_oe, bus0.HLDA, bus0.IO_OR_M, bus0.DT_OR_R}, 4'b1000);
    chk("rst_address", bus0.ADDRESS, 20'd0);
    chk("rst_data_out", bus0.DATA_OUT, 8'd0);
    chk("rst_core", {ack, timeout, rdata}, 10'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);

    for (int i = 0; i < 5; i++)
      xfer(vecs[i].t, vecs[i].a, vecs[i].wd, vecs[i].nw, vecs[i].din, vecs[i].exp_rd,
           vecs[i].exp_lat);

    // Random transfers: reads return DATA_IN, writes leave rdata untouched.
    model_rd = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rt = 3'($urandom_range(3, 0));
      ra = 20'($urandom());
      rw = 8'($urandom());
      rd = 8'($urandom());
      rn = int'($urandom_range(3, 0));
      if (!rt[0]) model_rd = rd;
      xfer(rt, ra, rw, rn, rd, model_rd, 4 + rn);
      if ($urandom_range(1, 0) == 1) repeat (8) @(negedge clock);
    end

    // INTA with HOLD raised between the halves.
    req_type = 3'd4; req_address = 20'hABCDE; bus0.DATA_IN = 8'h11; bus0.RDY = 1'b1;
    req = 1'b1;
    pulses = 0; acks = 0; rise1 = 0; fall2 = 0; prev = 1'b1;
    early = 1'b0; bad_addr = 1'b0; granted = 1'b0; ack_rd = 8'h00;
    for (int k = 0; k < 400 && !granted; k++) begin
      @(negedge clock);
      if (prev && !bus0.INTA_N) begin
        pulses++;
        if (pulses == 2) fall2 = int'(edge_cnt);
      end
      if (!prev && bus0.INTA_N && pulses == 1) begin
        rise1 = int'(edge_cnt);
        bus0.DATA_IN = 8'h08;
        bus0.HOLD = 1'b1;
      end
      prev = bus0.INTA_N;
      if (!bus0.INTA_N && (bus0.ADDRESS != 20'd0 || !bus0.IO_OR_M)) bad_addr = 1'b1;
      if (bus0.HLDA && acks == 0) early = 1'b1;
      if (ack) begin
        acks++;
        ack_rd = rdata;
        req = 1'b0;
      end
      if (bus0.HLDA && acks > 0) granted = 1'b1;
    end
    chk("inta_pulses", pulses, 2);
    chk("inta_gap_edges", fall2 - rise1, 4);
    chk("inta_acks", acks, 1);
    chk("inta_vector", ack_rd, 8'h08);
    chk("inta_addr_io", bad_addr, 1'b0);
    chk("inta_hold_deferred", early, 1'b0);
    chk("inta_hold_granted", {granted, bus0.bus_oe}, 2'b10);
    bus0.HOLD = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      if (!bus0.HLDA) done = 1'b1;
    end
    chk("inta_hold_release", {done, bus0.bus_oe}, 2'b11);
    repeat (8) @(negedge clock);

    // HOLD raised during T2 of a read, with another request pending behind it.
    req_type = 3'd0; req_address = 20'h01234; bus0.DATA_IN = 8'h9E; req = 1'b1;
    granted = 1'b0; acks = 0; ack_rd = 8'h00;
    for (int k = 0; k < 400 && !granted; k++) begin
      @(negedge clock);
      if (!bus0.RD_N) bus0.HOLD = 1'b1;
      if (ack) begin
        acks++;
        ack_rd = rdata;
        req_address = 20'h05678;
        bus0.DATA_IN = 8'h44;
      end
      if (bus0.HLDA) granted = 1'b1;
    end
    chk("hold_read_data", ack_rd, 8'h9E);
    chk("hold_granted", {granted, bus0.bus_oe, acks[1:0]}, 4'b1001);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clock);
      if (bus0.ALE || !bus0.HLDA || bus0.bus_oe) ok = 1'b0;
    end
    chk("hold_parked", ok, 1'b1);
    bus0.HOLD = 1'b0;
    eh = -100; ea = 0; done = 1'b0; ack_rd = 8'h00;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clock);
      if (!bus0.HLDA && eh < 0) eh = int'(edge_cnt);
      if (bus0.ALE && ea == 0) ea = int'(edge_cnt);
      if (ack) begin
        done = 1'b1;
        ack_rd = rdata;
        req = 1'b0;
      end
    end
    chk("hold_one_ti", ea - eh, 1);
    chk("hold_pending_data", ack_rd, 8'h44);
    chk("hold_pending_addr", bus0.ADDRESS, 20'h05678);
    repeat (8) @(negedge clock);

    // Forced termination on the MAX_WAIT=2 instance with RDY stuck low.
    req2_type = 3'd0; req2_address = 20'h00100; bus2.DATA_IN = 8'h77; bus2.RDY = 1'b0;
    req2 = 1'b1;
    t1e = -1; done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clock);
      if (t1e < 0 && bus2.ALE) t1e = int'(edge_cnt);
      if (ack2) begin
        done = 1'b1;
        chk("to_latency", int'(edge_cnt) - t1e + 1, 6);
        chk("to_flag", timeout2, 1'b1);
        chk("to_rdata", rdata2, 8'hFF);
        req2 = 1'b0;
      end
    end
    if (!done) chk("to_ack_seen", 1'b0, 1'b1);
    @(negedge clock);
    chk("to_pulse_width", {ack2, timeout2}, 2'b00);

    // Reset pulsed in the middle of a wait state of an IO write.
    req_type = 3'd3; req_address = 20'h000A0; req_wdata = 8'h3C; bus0.RDY = 1'b0;
    req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clock);
      if (!bus0.WR_N) done = 1'b1;
    end
    chk("rst_tw_started", done, 1'b1);
    repeat (12) @(negedge clock);
    chk("rst_tw_in_wait", bus0.WR_N, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_tw_strobes", {bus0.RD_N, bus0.WR_N, bus0.INTA_N, bus0.DEN_N, bus0.ALE}, 5'b11110);
    chk("rst_tw_ctrl", {bus0.bus_oe, bus0.HLDA, bus0.IO_OR_M, bus0.DT_OR_R}, 4'b1000);
    chk("rst_tw_bus", {bus0.ADDRESS, bus0.DATA_OUT}, 28'd0);
    req = 1'b0;
    bus0.RDY = 1'b1;
    #20 reset_n = 1'b1;
    ok = 1'b1;
    repeat (48) begin
      @(negedge clock);
      if (ack || bus0.ALE || !bus0.WR_N || !bus0.DEN_N) ok = 1'b0;
    end
    chk("rst_tw_idle", ok, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
